// File: rtl/nmr_voter.sv
// rtl/nmr_voter.sv - clocked N-modular-redundancy bitwise-majority voter
//
// Votes N replica words of W bits into one registered word, tracks per-replica
// runs of disagreement and retires a replica after K in a row, keeping at
// least three replicas active. Raises a sticky alarm on ties or when a
// retirement would leave fewer than three voters.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   valid_in, din     vote set; replica i in din[i*W +: W]
//   clr_fault         strobe: reinstate replicas, clear counters and alarm
//   valid_out         dout/disagree/no_majority refreshed this cycle
//   dout              voted word
//   disagree          per-replica mismatch against dout
//   masked            sticky per-replica retirement
//   no_majority       some bit of dout was a tie
//   fail              sticky alarm
module nmr_voter #(
  parameter int N = 5,
  parameter int W = 8,
  parameter int K = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  input  logic [N*W-1:0] din,
  input  logic         clr_fault,
  output logic         valid_out,
  output logic [W-1:0] dout,
  output logic [N-1:0] disagree,
  output logic [N-1:0] masked,
  output logic         no_majority,
  output logic         fail
);

  localparam logic [7:0] KC = 8'(K);

  logic [W-1:0] dout_q, dout_d, vote;
  logic [W-1:0] tie;
  logic [N-1:0] disagree_q, disagree_d, dis;
  logic [N-1:0] masked_q, masked_d, active, cand;
  logic         valid_q, no_maj_q, no_maj_d;
  logic         fail_q, fail_d, retire_ok;
  logic [7:0]   cnt_q [N];
  logic [7:0]   cnt_d [N];
  logic [7:0]   cnt_nx [N];
  int           act_n, ones, n_cand;

  // Vote, disagreement and counter look-ahead against the current mask.
  always_comb begin
    active = ~masked_q;
    act_n  = 0;
    for (int i = 0; i < N; i++) if (active[i]) act_n++;

    // A tie keeps the previous output bit so dout never flips on no evidence.
    vote = dout_q;
    tie  = '0;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int i = 0; i < N; i++) if (active[i] && din[i*W+b]) ones++;
      if (2 * ones > act_n)      vote[b] = 1'b1;
      else if (2 * ones < act_n) vote[b] = 1'b0;
      else                       tie[b]  = 1'b1;
    end

    n_cand = 0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      dis[i]    = active[i] && (din[i*W +: W] != vote);
      cnt_nx[i] = cnt_q[i];
      if (active[i]) begin
        if (dis[i]) cnt_nx[i] = (cnt_q[i] >= KC) ? KC : cnt_q[i] + 8'd1;
        else        cnt_nx[i] = 8'd0;
      end
      cand[i] = active[i] && (cnt_nx[i] == KC);
      if (cand[i]) n_cand++;
    end
    retire_ok = (act_n - n_cand) >= 3;
  end

  // Next state: clear overrides any counter/mask effect of a same-cycle vote.
  always_comb begin
    dout_d     = dout_q;
    disagree_d = disagree_q;
    no_maj_d   = no_maj_q;
    masked_d   = masked_q;
    fail_d     = fail_q;
    for (int i = 0; i < N; i++) cnt_d[i] = cnt_q[i];

    if (valid_in) begin
      dout_d     = vote;
      disagree_d = dis;
      no_maj_d   = |tie;
    end

    if (clr_fault) begin
      masked_d = '0;
      fail_d   = 1'b0;
      for (int i = 0; i < N; i++) cnt_d[i] = 8'd0;
    end else if (valid_in) begin
      for (int i = 0; i < N; i++) cnt_d[i] = cnt_nx[i];
      if (retire_ok) masked_d = masked_q | cand;
      else           fail_d   = 1'b1;
      if (|tie) fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      dout_q     <= '0;
      disagree_q <= '0;
      no_maj_q   <= 1'b0;
      masked_q   <= '0;
      fail_q     <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= 8'd0;
    end else begin
      valid_q    <= valid_in;
      dout_q     <= dout_d;
      disagree_q <= disagree_d;
      no_maj_q   <= no_maj_d;
      masked_q   <= masked_d;
      fail_q     <= fail_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign valid_out   = valid_q;
  assign dout        = dout_q;
  assign disagree    = disagree_q;
  assign no_majority = no_maj_q;
  assign masked      = masked_q;
  assign fail        = fail_q;

endmodule

// File: tb/tb_nmr_voter.sv
// tb/tb_nmr_voter.sv - scoreboard testbench for nmr_voter
module tb_nmr_voter;

  localparam int N = 5;
  localparam int W = 8;
  localparam int K = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic [N*W-1:0] din = '0;
  logic         clr_fault = 1'b0;
  logic         valid_out;
  logic [W-1:0] dout;
  logic [N-1:0] disagree, masked;
  logic         no_majority, fail;

  nmr_voter #(.N(N), .W(W), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .din(din),
    .clr_fault(clr_fault), .valid_out(valid_out), .dout(dout),
    .disagree(disagree), .masked(masked), .no_majority(no_majority),
    .fail(fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [N-1:0] dis;
    logic         nm;
  } exp_t;

  exp_t         sb [$];
  logic [N-1:0] m_mask;
  int           m_cnt [N];
  logic         m_fail;
  logic [W-1:0] m_dout;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [N*W-1:0] pk(input logic [7:0] r0, r1, r2, r3, r4);
    return {r4, r3, r2, r1, r0};
  endfunction

  task automatic model_reset();
    m_mask = '0;
    m_fail = 1'b0;
    m_dout = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    sb.delete();
  endtask

  // Reference vote: counts voters per bit, then applies the retirement rule.
  task automatic model_vote(input logic [N*W-1:0] d, input logic c);
    exp_t e;
    int a, ones, nc;
    logic [N-1:0] cd;
    logic [W-1:0] w;
    a = 0;
    for (int i = 0; i < N; i++) if (!m_mask[i]) a++;
    e.nm = 1'b0;
    e.d  = m_dout;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int i = 0; i < N; i++) if (!m_mask[i] && d[i*W+b]) ones++;
      if (ones * 2 > a) e.d[b] = 1'b1;
      else if (ones * 2 < a) e.d[b] = 1'b0;
      else e.nm = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      w = d[i*W +: W];
      e.dis[i] = !m_mask[i] && (w != e.d);
    end
    sb.push_back(e);
    m_dout = e.d;
    if (c) begin
      m_mask = '0;
      m_fail = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      nc = 0;
      cd = '0;
      for (int i = 0; i < N; i++) begin
        if (!m_mask[i]) begin
          m_cnt[i] = e.dis[i] ? ((m_cnt[i] + 1 > K) ? K : m_cnt[i] + 1) : 0;
          if (m_cnt[i] == K) begin
            cd[i] = 1'b1;
            nc++;
          end
        end
      end
      if (a - nc >= 3) m_mask = m_mask | cd;
      else m_fail = 1'b1;
      if (e.nm) m_fail = 1'b1;
    end
  endtask

  task automatic step(input logic v, input logic [N*W-1:0] d, input logic c);
    exp_t e;
    @(negedge clk);
    valid_in  = v;
    din       = d;
    clr_fault = c;
    if (v) model_vote(d, c);
    else if (c) begin
      m_mask = '0;
      m_fail = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    clr_fault = 1'b0;
    chk("valid_out", valid_out, v);
    if (valid_out) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("dout", dout, e.d);
        chk("disagree", disagree, e.dis);
        chk("no_majority", no_majority, e.nm);
      end
    end else begin
      chk("dout_hold", dout, m_dout);
    end
    chk("masked", masked, m_mask);
    chk("fail", fail, m_fail);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_disagree"}, disagree, 0);
    chk({tag, "_masked"}, masked, 0);
    chk({tag, "_nm"}, no_majority, 0);
    chk({tag, "_fail"}, fail, 0);
  endtask

  initial begin
    logic [7:0] base, w;
    logic [N*W-1:0] d;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Unanimous vote.
    step(1, pk(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5), 0);
    chk("unanimous_dout", dout, 8'hA5);

    // Replica 2 outvoted three times, then retired.
    for (int i = 0; i < 3; i++) begin
      step(1, pk(8'h3C, 8'h3C, 8'hFF, 8'h3C, 8'h3C), 0);
      chk("r2_disagree", disagree, 5'b00100);
    end
    chk("r2_masked", masked, 5'b00100);
    chk("r2_fail", fail, 0);
    step(0, '0, 1);

    // Disagree, disagree, agree, disagree, disagree: counter restarts.
    step(1, pk(8'h3C, 8'h3C, 8'hFF, 8'h3C, 8'h3C), 0);
    step(1, pk(8'h3C, 8'h3C, 8'hFF, 8'h3C, 8'h3C), 0);
    step(1, pk(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C), 0);
    step(1, pk(8'h3C, 8'h3C, 8'hFF, 8'h3C, 8'h3C), 0);
    step(1, pk(8'h3C, 8'h3C, 8'hFF, 8'h3C, 8'h3C), 0);
    chk("r2_not_masked", masked, 5'b00000);
    step(1, pk(8'h3C, 8'h3C, 8'hFF, 8'h3C, 8'h3C), 0);
    for (int i = 0; i < 3; i++) step(1, pk(8'h3C, 8'h3C, 8'hFF, 8'h3C, 8'h00), 0);
    chk("r24_masked", masked, 5'b10100);

    // A=3: replica 0 cannot be retired, alarm instead.
    for (int i = 0; i < 3; i++) step(1, pk(8'h00, 8'h3C, 8'hFF, 8'h3C, 8'hFF), 0);
    chk("a3_masked", masked, 5'b10100);
    chk("a3_fail", fail, 1);
    chk("a3_dout", dout, 8'h3C);

    // Clear with a vote: old mask picks 0x11, full set would pick 0x22.
    step(1, pk(8'h22, 8'h11, 8'h22, 8'h11, 8'h22), 1);
    chk("clr_dout", dout, 8'h11);
    chk("clr_masked", masked, 0);
    chk("clr_fail", fail, 0);

    // Retire replica 4, then an even split ties every bit.
    for (int i = 0; i < 3; i++) step(1, pk(8'h55, 8'h55, 8'h55, 8'h55, 8'hAA), 0);
    step(1, pk(8'h55, 8'h55, 8'h55, 8'h55, 8'h55), 0);
    step(0, '0, 0);
    step(1, pk(8'h0F, 8'h0F, 8'hF0, 8'hF0, 8'h00), 0);
    chk("tie_dout", dout, 8'h55);
    chk("tie_nm", no_majority, 1);
    chk("tie_fail", fail, 1);

    // Asynchronous reset mid-stream drops the in-flight vote.
    @(negedge clk);
    valid_in = 1'b1;
    din = pk(8'h12, 8'h12, 8'h12, 8'h12, 8'h12);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // Full replica set is back: replica 4 is part of the majority.
    step(1, pk(8'h88, 8'h88, 8'h77, 8'h77, 8'h77), 0);
    chk("post_reset_dout", dout, 8'h77);

    // Random votes with occasional corrupted replicas and clears.
    for (int t = 0; t < 60; t++) begin
      base = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        w = base;
        if ($urandom_range(3) == 0) w = base ^ 8'($urandom_range(255, 1));
        d[i*W +: W] = w;
      end
      step(($urandom_range(7) != 0), d, ($urandom_range(15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
